transmitter: RTL and testbench

- Serializes a 7-bit word onto a single-wire, idle-high serial line.
- Frame format: start bit (0), 7 data bits LSB first, even-parity bit, then STOP_BITS stop bits (1).
- The parity bit is the XOR of the 7 data bits, so the receiver's parity check passes.
- Sits on the transmit side of the serial link and feeds the receiver's serial_in directly; both ends share one clock.

---
 rtl/transmitter.sv | 128 ++++++++++++
 tb/tb_transmitter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// Serial transmitter: start bit, 7 data bits LSB first, even parity, STOP_BITS stop bits; idle high.
// Optional TX_PARITY_INJECT_EN adds a parity_inject input that inverts the sent parity bit.
module transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       valid,
    input  logic [6:0] data_in,
`ifdef TX_PARITY_INJECT_EN
    input  logic       parity_inject,
`endif
    output logic       ready,
    output logic       serial_out,
    output logic       tx_done
);

    localparam int unsigned STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_MAX  = (STOP_LEN > CLKS_PER_BIT) ? STOP_LEN : CLKS_PER_BIT;
    localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'((STOP_LEN >= 2) ? STOP_LEN - 2 : 0);
    localparam bit               STOP_ONE  = (STOP_LEN == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift;
    logic             parity;

    // serial_out is loaded with the level of the state being entered, so the line is fully registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            ready      <= 1'b1;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        shift      <= data_in;
`ifdef TX_PARITY_INJECT_EN
                        parity     <= (^data_in) ^ parity_inject;
`else
                        parity     <= ^data_in;
`endif
                        state      <= START;
                        ready      <= 1'b0;
                        serial_out <= 1'b0;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                    end
                end
                START: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt    <= '0;
                        state      <= DATA;
                        serial_out <= shift[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'd6) begin
                            bit_cnt    <= '0;
                            state      <= PARITY;
                            serial_out <= parity;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            shift      <= shift >> 1;
                            serial_out <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt    <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                        tx_done    <= STOP_ONE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // tx_done is registered, so it is raised one cycle ahead of the final stop cycle
                    if (!STOP_ONE && cyc_cnt == STOP_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (cyc_cnt == STOP_LAST) begin
                        cyc_cnt <= '0;
                        state   <= IDLE;
                        ready   <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ready      <= 1'b1;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: default instance with frame decoder/scoreboard, plus a CLKS_PER_BIT=4, STOP_BITS=2 instance.
module tb_transmitter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid = 1'b0;
    logic [6:0] data_in = '0;
    logic       ready, serial_out, tx_done;
    logic       valid4 = 1'b0;
    logic [6:0] data4 = '0;
    logic       ready4, so4, done4;
    logic       inj = 1'b0;
`ifdef TX_PARITY_INJECT_EN
    logic       inj4 = 1'b0;
`endif

    always #5 clk = ~clk;

    transmitter dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid      (valid),
        .data_in    (data_in),
`ifdef TX_PARITY_INJECT_EN
        .parity_inject(inj),
`endif
        .ready      (ready),
        .serial_out (serial_out),
        .tx_done    (tx_done)
    );

    transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .valid      (valid4),
        .data_in    (data4),
`ifdef TX_PARITY_INJECT_EN
        .parity_inject(inj4),
`endif
        .ready      (ready4),
        .serial_out (so4),
        .tx_done    (done4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: {expected parity, data} pushed at each accepting edge of the default instance
    logic [7:0] sb_q[$];
    int         acc_cyc[$];
    logic       acc_line[$];
    int         cyc_n = 0;

    always @(posedge clk) begin
        cyc_n++;
        if (!rstn) begin
            sb_q.delete();
        end else if (valid && ready) begin
            sb_q.push_back({(^data_in) ^ inj, data_in});
            acc_cyc.push_back(cyc_n);
            acc_line.push_back(serial_out);
        end
    end

    // Frame decoder standing in for the one-bit-per-clock receiver
    int         rx_cnt = 0;
    logic [6:0] rx_data = '0;
    logic       rx_par = 1'b0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (!rstn) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (serial_out == 1'b0) rx_cnt = 1;
        end else if (rx_cnt <= 7) begin
            rx_data[rx_cnt-1] = serial_out;
            rx_cnt++;
        end else if (rx_cnt == 8) begin
            rx_par = serial_out;
            rx_cnt++;
        end else begin
            logic [7:0] exp;
            check("rx_stop", 32'(serial_out), 32'(1));
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected_frame: got data %0h with empty scoreboard", rx_data);
            end else begin
                exp = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(exp[6:0]));
                check("rx_parity_ok_n", 32'(rx_par ^ (^rx_data)), 32'(exp[7] ^ (^exp[6:0])));
            end
            rx_cnt = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: ready still 0 after %0d cycles", n);
        end
    endtask

    // Send one word on the default instance and check every line cycle against frame f (bit i = cycle i)
    task automatic send_check(input logic [6:0] d, input logic [9:0] f, input logic pinj);
        wait_ready();
        valid   = 1'b1;
        data_in = d;
        inj     = pinj;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 7'($urandom);
        inj     = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            check("frame_bit", 32'(serial_out), 32'(f[j]));
            check("frame_ready", 32'(ready), 32'(0));
            check("frame_done", 32'(tx_done), 32'(j == 9));
        end
        @(negedge clk);
        check("post_ready", 32'(ready), 32'(1));
        check("post_line", 32'(serial_out), 32'(1));
    endtask

    typedef struct {
        logic [6:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 7'h55, frame: 10'b1010101010};
        vecs[1] = '{data: 7'h01, frame: 10'b1100000010};
        vecs[2] = '{data: 7'h00, frame: 10'b1000000000};
        vecs[3] = '{data: 7'h7F, frame: 10'b1111111110};
        vecs[4] = '{data: 7'h3C, frame: 10'b1001111000};

        // Reset state
        #12;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_line", 32'(serial_out), 32'(1));
        check("rst_done", 32'(tx_done), 32'(0));
        check("rst_ready4", 32'(ready4), 32'(1));
        check("rst_line4", 32'(so4), 32'(1));
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send_check(vecs[i].data, vecs[i].frame, 1'b0);
        end

        // valid held high across two words: accepts exactly one frame plus one idle cycle apart
        wait_ready();
        begin
            int base;
            int n;
            base = acc_cyc.size();
            valid   = 1'b1;
            data_in = 7'h2A;
            @(negedge clk);
            data_in = 7'h13;
            n = 0;
            while (acc_cyc.size() < base + 2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            valid = 1'b0;
            if (acc_cyc.size() < base + 2) begin
                checks++;
                errors++;
                $display("FAIL b2b_accept: second word not accepted within %0d cycles", n);
            end else begin
                check("b2b_spacing", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'(11));
                check("b2b_idle_gap", 32'(acc_line[base+1]), 32'(1));
            end
            repeat (14) @(negedge clk);
            check("b2b_drained", 32'(sb_q.size()), 32'(0));
        end

        // Reset during data bit 3
        wait_ready();
        valid   = 1'b1;
        data_in = 7'h55;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_bit3", 32'(serial_out), 32'(0));
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_line", 32'(serial_out), 32'(1));
        check("mid_rst_ready", 32'(ready), 32'(1));
        check("mid_rst_done", 32'(tx_done), 32'(0));
        done_cnt = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_no_done", 32'(done_cnt), 32'(0));
        check("mid_idle_line", 32'(serial_out), 32'(1));
        send_check(7'h55, 10'b1010101010, 1'b0);

        // CLKS_PER_BIT=4, STOP_BITS=2 instance
        begin
            logic [9:0] f4;
            int         d4;
            f4 = 10'b1111111110;
            d4 = 0;
            @(negedge clk);
            check("w_ready4", 32'(ready4), 32'(1));
            valid4 = 1'b1;
            data4  = 7'h7F;
            @(negedge clk);
            valid4 = 1'b0;
            data4  = 7'h00;
            for (int i = 0; i < 44; i++) begin
                if (i > 0) @(negedge clk);
                check("w_bit", 32'(so4), 32'((i / 4 < 10) ? f4[i/4] : 1'b1));
                check("w_done", 32'(done4), 32'(i == 43));
                if (done4) d4++;
            end
            @(negedge clk);
            check("w_done_once", 32'(d4), 32'(1));
            check("w_ready_after", 32'(ready4), 32'(1));
            check("w_line_after", 32'(so4), 32'(1));
        end

`ifdef TX_PARITY_INJECT_EN
        send_check(7'h55, 10'b1110101010, 1'b1);
        send_check(7'h55, 10'b1010101010, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty_end", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
